// File: rtl/dense_layer_tm.sv
// Time-multiplexed dense layer: NUM_MACS shared MAC units sweep NUM_NEURONS neurons group by group.
// Define DENSE_LAYER_SATURATE_EN to saturate requantised results; otherwise they wrap to W bits.
package dense_layer_tm_pkg;
    typedef enum logic {RELU, IDENTITY} activation_type;
endpackage

module dense_layer_tm
    import dense_layer_tm_pkg::*;
#(
    parameter int unsigned    INTEGER_WIDTH  = 8,
    parameter int unsigned    FRACTION_WIDTH = 8,
    parameter int unsigned    NUM_INPUTS     = 16,
    parameter int unsigned    NUM_NEURONS    = 16,
    parameter int unsigned    NUM_MACS       = 4,
    parameter activation_type ACTIVATION     = RELU,
    localparam int unsigned   W  = INTEGER_WIDTH + FRACTION_WIDTH,
    localparam int unsigned   NW = (NUM_NEURONS > 1) ? $clog2(NUM_NEURONS) : 1,
    localparam int unsigned   IW = $clog2(NUM_INPUTS + 1)
) (
    input  logic                                          clock,
    input  logic                                          reset,
    input  logic                                          inputs_ready,
    input  logic signed [INTEGER_WIDTH-1:-FRACTION_WIDTH] inputs [NUM_INPUTS],
    input  logic                                          weight_write_enable,
    input  logic [NW-1:0]                                 weight_write_neuron,
    input  logic [IW-1:0]                                 weight_write_index,
    input  logic signed [INTEGER_WIDTH-1:-FRACTION_WIDTH] weight_write_data,
    output logic signed [INTEGER_WIDTH-1:-FRACTION_WIDTH] outputs [NUM_NEURONS],
    output logic                                          outputs_ready,
    output logic                                          busy
);

    if (NUM_MACS == 0 || (NUM_NEURONS % NUM_MACS) != 0) begin : g_bad_num_macs
        $error("dense_layer_tm: NUM_MACS must divide NUM_NEURONS");
    end

    localparam int unsigned G  = NUM_NEURONS / NUM_MACS;
    localparam int unsigned AW = 2 * W + $clog2(NUM_INPUTS + 1);
    localparam int unsigned XW = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1;
    localparam int unsigned GW = (G > 1) ? $clog2(G) : 1;

    localparam logic [1:0] S_IDLE     = 2'd0;
    localparam logic [1:0] S_MAC      = 2'd1;
    localparam logic [1:0] S_ACTIVATE = 2'd2;
    localparam logic [1:0] S_DONE     = 2'd3;

    typedef logic signed [INTEGER_WIDTH-1:-FRACTION_WIDTH] fix_t;

    localparam logic signed [AW:0] SAT_MAX = {{(AW + 2 - W){1'b0}}, {(W - 1){1'b1}}};
    localparam logic signed [AW:0] SAT_MIN = {{(AW + 2 - W){1'b1}}, {(W - 1){1'b0}}};

    logic [1:0]           state_q, state_d;
    logic [XW-1:0]        index_q, index_d;
    logic [GW-1:0]        group_q, group_d;
    fix_t                 inputs_q  [NUM_INPUTS];
    fix_t                 inputs_d  [NUM_INPUTS];
    logic signed [AW-1:0] acc_q     [NUM_MACS];
    logic signed [AW-1:0] acc_d     [NUM_MACS];
    fix_t                 outputs_q [NUM_NEURONS];
    fix_t                 outputs_d [NUM_NEURONS];

    // Index NUM_INPUTS of each row holds the bias.
    fix_t                 mem_q [NUM_NEURONS][NUM_INPUTS+1];
    logic                 mem_we;

    logic [NW-1:0]         neuron_idx [NUM_MACS];
    logic signed [2*W-1:0] prod       [NUM_MACS];
    logic signed [AW:0]    biased     [NUM_MACS];
    logic signed [AW:0]    shifted    [NUM_MACS];
    fix_t                  req        [NUM_MACS];
    fix_t                  act_val    [NUM_MACS];

    always_comb begin
        for (int unsigned m = 0; m < NUM_MACS; m++) begin
            neuron_idx[m] = NW'(group_q * NUM_MACS + m);
            prod[m]       = inputs_q[index_q] * mem_q[neuron_idx[m]][IW'(index_q)];
            biased[m]     = (AW+1)'(acc_q[m])
                          + ((AW+1)'(mem_q[neuron_idx[m]][NUM_INPUTS]) <<< FRACTION_WIDTH);
            shifted[m]    = biased[m] >>> FRACTION_WIDTH;
`ifdef DENSE_LAYER_SATURATE_EN
            if (shifted[m] > SAT_MAX) begin
                req[m] = {1'b0, {(W - 1){1'b1}}};
            end else if (shifted[m] < SAT_MIN) begin
                req[m] = {1'b1, {(W - 1){1'b0}}};
            end else begin
                req[m] = fix_t'(shifted[m]);
            end
`else
            req[m] = fix_t'(shifted[m]);
`endif
            if (ACTIVATION == RELU && req[m][INTEGER_WIDTH-1]) begin
                act_val[m] = '0;
            end else begin
                act_val[m] = req[m];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        index_d   = index_q;
        group_d   = group_q;
        inputs_d  = inputs_q;
        acc_d     = acc_q;
        outputs_d = outputs_q;
        mem_we    = 1'b0;
        case (state_q)
            S_IDLE: begin
                mem_we = weight_write_enable
                      && (32'(weight_write_index) <= NUM_INPUTS)
                      && (32'(weight_write_neuron) < NUM_NEURONS);
                if (inputs_ready) begin
                    inputs_d = inputs;
                    index_d  = '0;
                    group_d  = '0;
                    state_d  = S_MAC;
                end
            end
            S_MAC: begin
                for (int unsigned m = 0; m < NUM_MACS; m++) begin
                    acc_d[m] = acc_q[m] + AW'(prod[m]);
                end
                if (index_q == XW'(NUM_INPUTS - 1)) begin
                    state_d = S_ACTIVATE;
                end else begin
                    index_d = index_q + 1'b1;
                end
            end
            S_ACTIVATE: begin
                for (int unsigned m = 0; m < NUM_MACS; m++) begin
                    outputs_d[neuron_idx[m]] = act_val[m];
                    acc_d[m] = '0;
                end
                index_d = '0;
                if (group_q == GW'(G - 1)) begin
                    state_d = S_DONE;
                end else begin
                    group_d = group_q + 1'b1;
                    state_d = S_MAC;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            index_q <= '0;
            group_q <= '0;
            for (int unsigned m = 0; m < NUM_MACS; m++) acc_q[m] <= '0;
            for (int unsigned n = 0; n < NUM_NEURONS; n++) outputs_q[n] <= '0;
        end else begin
            state_q   <= state_d;
            index_q   <= index_d;
            group_q   <= group_d;
            inputs_q  <= inputs_d;
            acc_q     <= acc_d;
            outputs_q <= outputs_d;
        end
    end

    // Weight RAM survives reset; writes are only blocked while reset is asserted.
    always_ff @(posedge clock) begin
        if (mem_we && !reset) begin
            mem_q[weight_write_neuron][weight_write_index] <= weight_write_data;
        end
    end

    assign outputs       = outputs_q;
    assign outputs_ready = (state_q == S_DONE);
    assign busy          = (state_q != S_IDLE);

endmodule

// File: tb/tb_dense_layer_tm.sv
// Directed bench for dense_layer_tm: three instances (RELU/2 MACs, identity/2 MACs, RELU/4 MACs) share stimulus.
module tb_dense_layer_tm;

    logic              clock;
    logic              reset;
    logic              inputs_ready;
    logic signed [7:-8] in_vec [4];
    logic              weight_write_enable;
    logic [1:0]        weight_write_neuron;
    logic [2:0]        weight_write_index;
    logic signed [7:-8] weight_write_data;

    logic signed [7:-8] out_relu [4];
    logic signed [7:-8] out_id   [4];
    logic signed [7:-8] out_par  [4];
    logic rdy_relu, rdy_id, rdy_par;
    logic busy_relu, busy_id, busy_par;

    int passed = 0;
    int total  = 0;

    dense_layer_tm #(
        .INTEGER_WIDTH(8), .FRACTION_WIDTH(8), .NUM_INPUTS(4), .NUM_NEURONS(4),
        .NUM_MACS(2), .ACTIVATION(dense_layer_tm_pkg::RELU)
    ) dut (
        .clock(clock), .reset(reset), .inputs_ready(inputs_ready), .inputs(in_vec),
        .weight_write_enable(weight_write_enable), .weight_write_neuron(weight_write_neuron),
        .weight_write_index(weight_write_index), .weight_write_data(weight_write_data),
        .outputs(out_relu), .outputs_ready(rdy_relu), .busy(busy_relu)
    );

    dense_layer_tm #(
        .INTEGER_WIDTH(8), .FRACTION_WIDTH(8), .NUM_INPUTS(4), .NUM_NEURONS(4),
        .NUM_MACS(2), .ACTIVATION(dense_layer_tm_pkg::IDENTITY)
    ) dut_id (
        .clock(clock), .reset(reset), .inputs_ready(inputs_ready), .inputs(in_vec),
        .weight_write_enable(weight_write_enable), .weight_write_neuron(weight_write_neuron),
        .weight_write_index(weight_write_index), .weight_write_data(weight_write_data),
        .outputs(out_id), .outputs_ready(rdy_id), .busy(busy_id)
    );

    dense_layer_tm #(
        .INTEGER_WIDTH(8), .FRACTION_WIDTH(8), .NUM_INPUTS(4), .NUM_NEURONS(4),
        .NUM_MACS(4), .ACTIVATION(dense_layer_tm_pkg::RELU)
    ) dut_par (
        .clock(clock), .reset(reset), .inputs_ready(inputs_ready), .inputs(in_vec),
        .weight_write_enable(weight_write_enable), .weight_write_neuron(weight_write_neuron),
        .weight_write_index(weight_write_index), .weight_write_data(weight_write_data),
        .outputs(out_par), .outputs_ready(rdy_par), .busy(busy_par)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %04h expected %04h", tag, obs, exp);
    endtask

    // Expected vectors packed as neuron i at [16*i +: 16].
    task automatic chk_all(input string tag, input logic [63:0] er, input logic [63:0] ei,
                           input logic [63:0] ep);
        for (int i = 0; i < 4; i++) begin
            chk($sformatf("%s_relu%0d", tag, i), out_relu[i], er[16*i +: 16]);
            chk($sformatf("%s_id%0d", tag, i),   out_id[i],   ei[16*i +: 16]);
            chk($sformatf("%s_par%0d", tag, i),  out_par[i],  ep[16*i +: 16]);
        end
    endtask

    task automatic write_w(input int n, input int i, input logic [15:0] d);
        weight_write_enable = 1'b1;
        weight_write_neuron = 2'(n);
        weight_write_index  = 3'(i);
        weight_write_data   = d;
        tick();
        weight_write_enable = 1'b0;
    endtask

    task automatic load(input logic [15:0] w, input logic [15:0] b);
        for (int n = 0; n < 4; n++) begin
            for (int i = 0; i < 4; i++) write_w(n, i, w);
            write_w(n, 4, b);
        end
    endtask

    task automatic set_inputs(input logic [15:0] a, input logic [15:0] b,
                              input logic [15:0] c, input logic [15:0] d);
        in_vec[0] = a; in_vec[1] = b; in_vec[2] = c; in_vec[3] = d;
    endtask

    // Test-1 stimulus with per-cycle handshake checks; disturb injects a start at
    // cycle 4 and a weight write at cycle 5, both of which must be ignored.
    task automatic run_timed(input string tag, input bit disturb, input bit from_zero);
        set_inputs(16'h0100, 16'h0200, 16'h0300, 16'h0400);
        inputs_ready = 1'b1;
        tick();
        inputs_ready = 1'b0;
        for (int c = 1; c <= 13; c++) begin
            chk($sformatf("%s_busy_c%0d", tag, c),    16'(busy_relu), 16'(c <= 11));
            chk($sformatf("%s_rdy_c%0d", tag, c),     16'(rdy_relu),  16'(c == 11));
            chk($sformatf("%s_parbusy_c%0d", tag, c), 16'(busy_par),  16'(c <= 6));
            chk($sformatf("%s_parrdy_c%0d", tag, c),  16'(rdy_par),   16'(c == 6));
            if (from_zero && c == 6) begin
                chk($sformatf("%s_early_n0", tag), out_relu[0], 16'h0A80);
                chk($sformatf("%s_early_n2", tag), out_relu[2], 16'h0000);
            end
            if (disturb && c == 4) begin
                set_inputs(16'h0500, 16'h0500, 16'h0500, 16'h0500);
                inputs_ready = 1'b1;
            end
            if (disturb && c == 5) begin
                inputs_ready        = 1'b0;
                weight_write_enable = 1'b1;
                weight_write_neuron = 2'd2;
                weight_write_index  = 3'd1;
                weight_write_data   = 16'h7000;
            end
            tick();
            weight_write_enable = 1'b0;
        end
        chk_all(tag, {4{16'h0A80}}, {4{16'h0A80}}, {4{16'h0A80}});
    endtask

    initial begin
        int rdy_count;
        reset               = 1'b1;
        inputs_ready        = 1'b0;
        weight_write_enable = 1'b0;
        weight_write_neuron = '0;
        weight_write_index  = '0;
        weight_write_data   = '0;
        set_inputs(16'h0, 16'h0, 16'h0, 16'h0);
        tick();
        tick();
        reset = 1'b0;

        chk("rst_busy", 16'(busy_relu), 16'h0);
        chk("rst_rdy",  16'(rdy_relu),  16'h0);
        chk("rst_parbusy", 16'(busy_par), 16'h0);
        chk_all("rst", 64'h0, 64'h0, 64'h0);

        // Basic run: weights 1.0, bias 0.5, inputs 1..4 -> 10.5
        load(16'h0100, 16'h0080);
        run_timed("t1", 1'b0, 1'b1);

        // Start at cycle 4 and weight write at cycle 5 are ignored.
        run_timed("t4", 1'b1, 1'b0);

        // Reset mid-run at cycle 5, then a clean restart.
        set_inputs(16'h0100, 16'h0200, 16'h0300, 16'h0400);
        inputs_ready = 1'b1;
        tick();
        inputs_ready = 1'b0;
        for (int c = 1; c <= 4; c++) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("t5_rst_busy",    16'(busy_relu), 16'h0);
        chk("t5_rst_rdy",     16'(rdy_relu),  16'h0);
        chk("t5_rst_parrdy",  16'(rdy_par),   16'h0);
        chk("t5_rst_parbusy", 16'(busy_par),  16'h0);
        chk_all("t5_rst", 64'h0, 64'h0, 64'h0);
        run_timed("t5", 1'b0, 1'b1);

        // ReLU vs identity: weights -1.0, inputs 1.0; neuron 3 bias written in the start cycle.
        load(16'hFF00, 16'h0000);
        set_inputs(16'h0100, 16'h0100, 16'h0100, 16'h0100);
        weight_write_enable = 1'b1;
        weight_write_neuron = 2'd3;
        weight_write_index  = 3'd4;
        weight_write_data   = 16'h0100;
        inputs_ready        = 1'b1;
        tick();
        inputs_ready        = 1'b0;
        weight_write_enable = 1'b0;
        rdy_count = 0;
        for (int c = 1; c <= 12; c++) begin
            if (rdy_relu) rdy_count++;
            tick();
        end
        chk("t2_rdy_count", 16'(rdy_count), 16'd1);
        chk_all("t2", 64'h0,
                {16'hFD00, 16'hFC00, 16'hFC00, 16'hFC00},
                64'h0);

        // Overflow: 4 * 100.0 = 400.0 does not fit in 8 integer bits.
        load(16'h0100, 16'h0000);
        set_inputs(16'h6400, 16'h6400, 16'h6400, 16'h6400);
        inputs_ready = 1'b1;
        tick();
        inputs_ready = 1'b0;
        for (int c = 1; c <= 12; c++) tick();
`ifdef DENSE_LAYER_SATURATE_EN
        chk_all("t3", {4{16'h7FFF}}, {4{16'h7FFF}}, {4{16'h7FFF}});
`else
        chk_all("t3", 64'h0, {4{16'h9000}}, 64'h0);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/dense_layer_tm.md
Name: dense_layer_tm

Overview:
- Time-multiplexed successor to the fully parallel dense layer.
- NUM_NEURONS neurons share NUM_MACS multiply-accumulate units. Neurons are processed in groups of NUM_MACS, with one input consumed per cycle.
- Weights and biases live in internal RAM, loaded through a write port.
- Drops in between layers in the network pipeline with the same inputs_ready/outputs_ready handshake, trading latency for DSP count.

Parameters:
- NUM_INPUTS, 16, inputs per neuron (>=1)
- NUM_NEURONS, 16, neurons/outputs (>=1)
- NUM_MACS, 4, parallel MAC units; must divide NUM_NEURONS, elaboration error otherwise
- ACTIVATION, RELU, activation_type; RELU clamps negatives to 0, any other value is identity

Ports:
- W = INTEGER_WIDTH+FRACTION_WIDTH; fixed-point signals declared signed [INTEGER_WIDTH-1:-FRACTION_WIDTH].
- clock  in  1  single clock; all logic on rising edge
- reset  in  1  synchronous, active-high
- inputs_ready  in  1  start pulse; sampled only in IDLE
- inputs  in  W x NUM_INPUTS  activation vector; latched on accepted start
- weight_write_enable  in  1  weight/bias RAM write strobe
- weight_write_neuron  in  clog2(NUM_NEURONS)  target neuron
- weight_write_index  in  clog2(NUM_INPUTS+1)  0..NUM_INPUTS-1 = weight; NUM_INPUTS = bias
- weight_write_data  in  W  value written
- outputs  out  W x NUM_NEURONS  layer results; registered, held between runs
- outputs_ready  out  1  one-cycle pulse when outputs are complete
- busy  out  1  high from the cycle after an accepted start until the DONE cycle inclusive

Behaviour:
- Reset, synchronous and active-high, has priority over everything:
  - state=IDLE, outputs all 0, outputs_ready=0, busy=0, accumulators 0.
  - Weight/bias RAM is not cleared.
- Derived quantities: G = NUM_NEURONS/NUM_MACS groups; group g, unit m computes neuron g*NUM_MACS+m.
- FSM states IDLE, MAC, ACTIVATE, DONE:
  - IDLE: if inputs_ready=1, latch inputs, set index=0 and group=0, go to MAC. Otherwise stay.
  - MAC: acc[m] += inputs[index] * w[neuron][index]. At index=NUM_INPUTS-1 go to ACTIVATE; otherwise index++.
  - ACTIVATE: write outputs[neuron] = act(requantise(acc[m] + bias<<FRACTION_WIDTH)), then clear acc and index. If the last group, go to DONE; otherwise group++ and go to MAC.
  - DONE: outputs_ready=1 for this single cycle, then go to IDLE.
- Latency: start accepted at cycle 0 gives outputs_ready at cycle G*(NUM_INPUTS+1)+1. The next start can be accepted in the cycle after DONE.
- Arithmetic:
  - Product is 2W signed with 2*FRACTION_WIDTH fraction bits.
  - Accumulator is 2W+clog2(NUM_INPUTS+1) bits, so it never overflows.
  - Requantise = arithmetic shift right FRACTION_WIDTH (floor), then reduce to W (see Optional Feature).
- Outputs of earlier groups update during the run. The full vector is valid only from the outputs_ready cycle and holds until the next run's first ACTIVATE.
- inputs_ready while busy or in DONE: ignored. No queueing, no effect on the current run.
- Weight writes: accepted only in IDLE, taking effect next cycle. Ignored while busy/DONE. An index > NUM_INPUTS is ignored.
- A write and a start in the same IDLE cycle: the write completes, and the run uses the new value.
- Reset mid-run: aborts the run immediately and applies the reset values above. No outputs_ready pulse.

Optional Feature:
- Macro DENSE_LAYER_SATURATE_EN.
- Defined: a requantised value above the W-bit max clamps to 0x7F..F, and below the min clamps to 0x80..0. This is applied before activation.
- Undefined: the value is truncated to the low W bits (two's-complement wrap).

Test Plan:
All tests use INTEGER_WIDTH=8, FRACTION_WIDTH=8, NUM_INPUTS=4, NUM_NEURONS=4, NUM_MACS=2 unless stated.
1. Basic run:
   - Stimulus: all weights 1.0, biases 0.5, inputs {1.0,2.0,3.0,4.0}, start at cycle 0.
   - Required: all outputs 10.5 (0x0A80); outputs_ready high only at cycle 11; busy high cycles 1-11.
2. ReLU/identity:
   - Stimulus: weights -1.0, bias 0, inputs all 1.0.
   - Required: RELU gives outputs 0; a non-RELU ACTIVATION gives -4.0 (0xFC00).
3. Overflow:
   - Stimulus: inputs all 100.0, weights 1.0, bias 0 (sum 400.0).
   - Required: with DENSE_LAYER_SATURATE_EN, 0x7FFF; without it, -112.0 (0x9000).
4. Busy protection:
   - Stimulus: second inputs_ready at cycle 4 with different inputs, plus a weight write at cycle 5.
   - Required: both ignored; results equal to test 1; a single outputs_ready at cycle 11.
5. Reset mid-run:
   - Stimulus: reset at cycle 5, then restart.
   - Required: next cycle outputs=0, busy=0, no outputs_ready; the restarted run matches test 1 at relative cycle 11.
6. Fully parallel:
   - Stimulus: NUM_MACS=4, same stimulus as test 1.
   - Required: identical outputs; outputs_ready at cycle 6.
